uart_mmio16: RTL and testbench
==============================

Name: uart_mmio16

Overview:
- Memory-mapped 8N1 asynchronous serial port for the 65Org16 system-on-chip.
- Sits on the peripheral side of the onchip bus at the 0xfe page (address bits [23:16] == 8'hfe). It replaces the i2c-tunnelled uart.
- Accepts CPU writes from the muxed databus and supplies read data into the peripheral mux. The top level registers that mux before it reaches the CPU.
- Holds a small TX FIFO and a small RX FIFO so the CPU can poll status without losing characters.

Parameters:
- CLKDIV, 434, clk cycles per bit (50 MHz / 115200); legal range 4..65535.
- DEPTH_LOG2, 2, log2 of each FIFO depth (default depth is 4 entries).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- res  input  1  reset, synchronous, active-low, sampled on posedge clk.
- cs  input  1  block select (page 0xfe decode from the top level).
- we  input  1  write strobe; 1 = CPU write, 0 = read.
- addr  input  1  register select: 0 = DATA, 1 = STATUS.
- din  input  16  write data; only [7:0] is used for DATA.
- dout  output  16  read data, combinational from addr and internal state.
- txd  output  1  serial transmit line, idle high.
- rxd  input  1  serial receive line, asynchronous.
- rx_irq  output  1  registered; 1 while the RX FIFO is non-empty.

Behaviour:
- Reset (res==0 at posedge):
  - txd=1, rx_irq=0.
  - Both FIFOs are empty and the overrun and frame-error flags are 0.
  - Both serial FSMs return to IDLE; this holds even if res asserts mid-frame.
  - dout reads 0x0002 at addr=1 and 0x0000 at addr=0.
- dout:
  - addr=0: {8'h00, RX FIFO head byte}, or 0x0000 when the RX FIFO is empty.
  - addr=1: {11'b0, frame_err, overrun, tx_idle, tx_not_full, rx_avail}.
- CPU write, DATA (cs&we&addr==0): pushes din[7:0] into the TX FIFO.
  - Fullness is taken from the start of the cycle. A write while full is dropped even if the transmitter pops in the same cycle.
- CPU write, STATUS (cs&we&addr==1): din[3]=1 clears overrun and din[4]=1 clears frame_err. Other bits are ignored.
- CPU read, DATA (cs&~we&addr==0): pops the RX FIFO at this posedge if it is non-empty; a read while empty has no effect.
  - Exactly one pop per selected read cycle.
  - Read of STATUS has no side effects.
- TX FSM, states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, txd=0, go to START.
  - Each state lasts CLKDIV cycles, counted by a bit counter that reloads at each bit boundary.
  - DATA shifts 8 bits out LSB first. STOP drives txd=1 for CLKDIV cycles.
  - Back-to-back: if the FIFO is non-empty at the end of STOP, the next START begins on the following cycle, with no extra idle bit.
  - tx_idle = (state==IDLE) & TX FIFO empty.
- RX FSM, states IDLE, START, DATA, STOP:
  - rxd passes through a 2-flop synchronizer; all RX latency is quoted after it.
  - IDLE: on a synchronized 1->0 transition, go to START and load the counter with CLKDIV/2.
  - START: at mid-bit, if the line is still 0 go to DATA; if it is 1 this is a glitch, return to IDLE and store nothing.
  - DATA: sample 8 bits at CLKDIV intervals, LSB first.
  - STOP: sample at mid stop bit.
    - 1: push the byte. If the FIFO is full the byte is dropped and overrun=1.
    - 0: discard the byte, frame_err=1.
    - Either way return to IDLE immediately, so a start edge can be caught within the second half of the stop bit.
- Simultaneous RX push and CPU pop on a full FIFO: fullness is taken from the start of the cycle, so the push is dropped, overrun is set and the pop proceeds.
- Flags are sticky until cleared by a STATUS write or by reset. A set event and a clear in the same cycle resolve to set.
- FIFO pointers are DEPTH_LOG2+1 bits wide, wrap modulo 2*depth, and full/empty are derived from the MSB.
- rx_irq = registered (RX count != 0), so it lags a push by 1 cycle.

Test Plan:
- Reset then idle, CLKDIV=8: res low for 2 cycles -> txd=1, read STATUS=0x0002, read DATA=0x0000, rx_irq=0.
- TX one byte: write DATA 0x00A5 -> txd low 1 cycle later for 8 cycles, then 1,0,1,0,0,1,0,1 (8 cycles each), then high 8 cycles. STATUS bit2 reads 0 during the frame and 1 after it.
- TX full: write 0x31..0x36 back-to-back -> the transmitter pops 0x31 immediately and 4 bytes are queued. The 6th write is dropped and STATUS bit1=0. Line output is 0x31..0x35 contiguous, with no gap between stop and start.
- RX good: drive the serial frame 0x3C at CLKDIV=8 -> rx_irq=1, read DATA=0x003C, the next read returns 0x0000 and rx_irq=0.
- RX errors:
  - Frame with stop bit 0 -> no push, STATUS bit4=1. Write STATUS 0x0010 -> bit4=0.
  - 5 frames without reads -> 4 stored, STATUS bit3=1.
  - A 2-cycle low glitch on rxd -> nothing stored.
- Reset mid-frame: assert res halfway through the TX data bits -> txd=1 the next cycle, TX FIFO empty, and no resumption after res deasserts.

Source files
------------

// File: rtl/uart_mmio16.sv
// Memory-mapped 8N1 UART for the 65Org16 peripheral page: DATA/STATUS registers,
// TX and RX FIFOs, and independent transmit/receive bit engines.
module uart_mmio16 #(
   parameter int CLKDIV     = 434,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic        clk,
   input  logic        res,
   input  logic        cs,
   input  logic        we,
   input  logic        addr,
   input  logic [15:0] din,
   output logic [15:0] dout,
   output logic        txd,
   input  logic        rxd,
   output logic        rx_irq
);

   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [15:0] DIV_M1 = 16'(CLKDIV - 1);
   // Edge detection already costs one cycle, so the half-bit reload is one short.
   localparam logic [15:0] DIV_HALF_M1 = 16'(CLKDIV / 2 - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   logic [7:0]    tx_mem_q [DEPTH];
   logic [7:0]    tx_mem_d [DEPTH];
   logic [7:0]    rx_mem_q [DEPTH];
   logic [7:0]    rx_mem_d [DEPTH];
   logic [PW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
   logic [PW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;

   state_t      tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        txd_q, txd_d;

   state_t      rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;

   logic overrun_q, overrun_d, frame_err_q, frame_err_d, rx_irq_q, rx_irq_d;

   logic       tx_empty, tx_full, rx_empty, rx_full, tx_idle;
   logic       tx_push, tx_pop, rx_push, rx_pop, rx_push_req, frame_set, overrun_set;
   logic       wr_data, wr_stat, rd_data, rx_fall;
   logic [7:0] tx_head, rx_head;
   logic       unused_din;

   assign unused_din = ^din[15:8];

   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_wptr_q[PW-1] != tx_rptr_q[PW-1]) &&
                     (tx_wptr_q[PW-2:0] == tx_rptr_q[PW-2:0]);
   assign rx_empty = (rx_wptr_q == rx_rptr_q);
   assign rx_full  = (rx_wptr_q[PW-1] != rx_rptr_q[PW-1]) &&
                     (rx_wptr_q[PW-2:0] == rx_rptr_q[PW-2:0]);
   assign tx_head  = tx_mem_q[tx_rptr_q[DEPTH_LOG2-1:0]];
   assign rx_head  = rx_mem_q[rx_rptr_q[DEPTH_LOG2-1:0]];

   // tx_idle is masked while res is held so STATUS reads 0x0002 during reset.
   assign tx_idle = (tx_state_q == S_IDLE) & tx_empty & res;

   assign wr_data = cs & we & ~addr;
   assign wr_stat = cs & we & addr;
   assign rd_data = cs & ~we & ~addr;
   assign rx_fall = rx_s3_q & ~rx_s2_q;

   assign txd    = txd_q;
   assign rx_irq = rx_irq_q;

   always_comb begin
      dout = 16'h0000;
      if (addr) dout = {11'b0, frame_err_q, overrun_q, tx_idle, ~tx_full, ~rx_empty};
      else if (!rx_empty) dout = {8'h00, rx_head};
   end

   // FIFO bookkeeping and sticky flags; all fullness decisions use start-of-cycle state.
   always_comb begin
      tx_push     = wr_data & ~tx_full;
      rx_push     = rx_push_req & ~rx_full;
      overrun_set = rx_push_req & rx_full;
      rx_pop      = rd_data & ~rx_empty;
      tx_mem_d    = tx_mem_q;
      rx_mem_d    = rx_mem_q;
      if (tx_push) tx_mem_d[tx_wptr_q[DEPTH_LOG2-1:0]] = din[7:0];
      if (rx_push) rx_mem_d[rx_wptr_q[DEPTH_LOG2-1:0]] = rx_sh_q;
      tx_wptr_d   = tx_wptr_q + {{DEPTH_LOG2{1'b0}}, tx_push};
      tx_rptr_d   = tx_rptr_q + {{DEPTH_LOG2{1'b0}}, tx_pop};
      rx_wptr_d   = rx_wptr_q + {{DEPTH_LOG2{1'b0}}, rx_push};
      rx_rptr_d   = rx_rptr_q + {{DEPTH_LOG2{1'b0}}, rx_pop};
      overrun_d   = overrun_set | (overrun_q & ~(wr_stat & din[3]));
      frame_err_d = frame_set | (frame_err_q & ~(wr_stat & din[4]));
      rx_irq_d    = ~rx_empty;
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         S_IDLE: begin
            txd_d = 1'b1;
            if (!tx_empty) begin
               tx_pop     = 1'b1;
               tx_sh_d    = tx_head;
               txd_d      = 1'b0;
               tx_cnt_d   = DIV_M1;
               tx_state_d = S_START;
            end
         end
         S_START: begin
            if (tx_cnt_q == 16'd0) begin
               txd_d      = tx_sh_q[0];
               tx_sh_d    = {1'b0, tx_sh_q[7:1]};
               tx_bit_d   = 3'd0;
               tx_cnt_d   = DIV_M1;
               tx_state_d = S_DATA;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
         end
         S_DATA: begin
            if (tx_cnt_q == 16'd0) begin
               tx_cnt_d = DIV_M1;
               if (tx_bit_q == 3'd7) begin
                  txd_d      = 1'b1;
                  tx_state_d = S_STOP;
               end else begin
                  txd_d    = tx_sh_q[0];
                  tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                  tx_bit_d = tx_bit_q + 3'd1;
               end
            end else tx_cnt_d = tx_cnt_q - 16'd1;
         end
         S_STOP: begin
            if (tx_cnt_q == 16'd0) begin
               // Chain straight into the next start bit when more data is queued.
               if (!tx_empty) begin
                  tx_pop     = 1'b1;
                  tx_sh_d    = tx_head;
                  txd_d      = 1'b0;
                  tx_cnt_d   = DIV_M1;
                  tx_state_d = S_START;
               end else tx_state_d = S_IDLE;
            end else tx_cnt_d = tx_cnt_q - 16'd1;
         end
         default: tx_state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rx_s1_d     = rxd;
      rx_s2_d     = rx_s1_q;
      rx_s3_d     = rx_s2_q;
      rx_state_d  = rx_state_q;
      rx_cnt_d    = rx_cnt_q;
      rx_bit_d    = rx_bit_q;
      rx_sh_d     = rx_sh_q;
      rx_push_req = 1'b0;
      frame_set   = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            if (rx_fall) begin
               rx_cnt_d   = DIV_HALF_M1;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == 16'd0) begin
               rx_cnt_d   = DIV_M1;
               rx_bit_d   = 3'd0;
               rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
         end
         S_DATA: begin
            if (rx_cnt_q == 16'd0) begin
               rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
               rx_cnt_d = DIV_M1;
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
         end
         S_STOP: begin
            // Leave at mid stop bit so a following start edge is not missed.
            if (rx_cnt_q == 16'd0) begin
               rx_push_req = rx_s2_q;
               frame_set   = ~rx_s2_q;
               rx_state_d  = S_IDLE;
            end else rx_cnt_d = rx_cnt_q - 16'd1;
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
      tx_sh_q  <= tx_sh_d;
      rx_sh_q  <= rx_sh_d;
   end

   always_ff @(posedge clk) begin
      if (!res) begin
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
         tx_state_q  <= S_IDLE;
         tx_cnt_q    <= '0;
         tx_bit_q    <= '0;
         txd_q       <= 1'b1;
         rx_state_q  <= S_IDLE;
         rx_cnt_q    <= '0;
         rx_bit_q    <= '0;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_s3_q     <= 1'b1;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
         rx_irq_q    <= 1'b0;
      end else begin
         tx_wptr_q   <= tx_wptr_d;
         tx_rptr_q   <= tx_rptr_d;
         rx_wptr_q   <= rx_wptr_d;
         rx_rptr_q   <= rx_rptr_d;
         tx_state_q  <= tx_state_d;
         tx_cnt_q    <= tx_cnt_d;
         tx_bit_q    <= tx_bit_d;
         txd_q       <= txd_d;
         rx_state_q  <= rx_state_d;
         rx_cnt_q    <= rx_cnt_d;
         rx_bit_q    <= rx_bit_d;
         rx_s1_q     <= rx_s1_d;
         rx_s2_q     <= rx_s2_d;
         rx_s3_q     <= rx_s3_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
         rx_irq_q    <= rx_irq_d;
      end
   end

endmodule

// File: tb/tb_uart_mmio16.sv
// Self-checking bench for uart_mmio16 at CLKDIV=8: register vectors, exact TX line
// timing, a serial frame decoder for TX output and a queue model for the RX side.
module tb_uart_mmio16;
   localparam int CLKDIV = 8;
   localparam int DL     = 2;

   logic        clk = 1'b0, res = 1'b0, cs = 1'b0, we = 1'b0, addr = 1'b0, rxd = 1'b1;
   logic [15:0] din = 16'h0;
   logic [15:0] dout;
   logic        txd, rx_irq;

   int checks = 0, failures = 0;
   int unsigned cyc = 0;
   logic [7:0]  tx_got[$];
   int unsigned tx_t[$];

   typedef struct {
      logic        we;
      logic        addr;
      logic [15:0] din;
      logic [15:0] exp_dout;
      logic        exp_irq;
      string       name;
   } vec_t;
   vec_t tbl[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_mmio16 #(.CLKDIV(CLKDIV), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .res(res), .cs(cs), .we(we), .addr(addr), .din(din),
      .dout(dout), .txd(txd), .rxd(rxd), .rx_irq(rx_irq)
   );

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic wr(input logic a, input logic [15:0] d);
      cs = 1'b1; we = 1'b1; addr = a; din = d;
      tick();
      cs = 1'b0; we = 1'b0;
   endtask

   task automatic rd(input logic a, output logic [15:0] v);
      cs = 1'b1; we = 1'b0; addr = a;
      #1 v = dout;
      tick();
      cs = 1'b0;
   endtask

   task automatic peek(input logic a, output logic [15:0] v);
      addr = a;
      #1 v = dout;
   endtask

   task automatic add_vec(input logic w, input logic a, input logic [15:0] d,
                          input logic [15:0] e, input logic i, input string n);
      vec_t v;
      v.we = w; v.addr = a; v.din = d; v.exp_dout = e; v.exp_irq = i; v.name = n;
      tbl.push_back(v);
   endtask

   task automatic run_tbl();
      foreach (tbl[i]) begin
         cs = 1'b1; we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din;
         #1;
         chk({tbl[i].name, "_dout"}, dout, tbl[i].exp_dout);
         chk({tbl[i].name, "_irq"}, {15'b0, rx_irq}, {15'b0, tbl[i].exp_irq});
         tick();
         cs = 1'b0; we = 1'b0;
      end
      tbl.delete();
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      idle(CLKDIV);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(CLKDIV);
      end
      rxd = stop;
      idle(CLKDIV);
      rxd = 1'b1;
   endtask

   task automatic wait_tx_idle(input int bound);
      int n;
      logic [15:0] s;
      n = 0;
      peek(1'b1, s);
      while (!s[2] && n < bound) begin
         tick();
         n++;
         peek(1'b1, s);
      end
      chk("tx_idle_reached", {15'b0, s[2]}, 16'h0001);
   endtask

   // Decodes every frame on txd by mid-bit sampling and records its start cycle.
   initial begin : tx_decoder
      int unsigned t0;
      logic [7:0]  b;
      forever begin
         tick();
         if (txd === 1'b0) begin
            t0 = cyc;
            idle(CLKDIV / 2);
            if (txd === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  idle(CLKDIV);
                  b[i] = txd;
               end
               idle(CLKDIV);
               if (txd === 1'b1) begin
                  tx_got.push_back(b);
                  tx_t.push_back(t0);
               end
            end
         end
      end
   end

   initial begin : main
      logic [15:0] v, e;
      logic [7:0]  bb;
      logic [7:0]  rxq[$];
      logic [7:0]  exq[$];
      logic        m_over, m_frame, st, saw_low;
      int          n;

      // Reset held for two edges
      res = 1'b0;
      idle(2);
      chk("rst_txd", {15'b0, txd}, 16'h0001);
      chk("rst_irq", {15'b0, rx_irq}, 16'h0000);
      peek(1'b1, v); chk("rst_status", v, 16'h0002);
      peek(1'b0, v); chk("rst_data", v, 16'h0000);
      res = 1'b1;
      add_vec(1'b0, 1'b1, 16'h0000, 16'h0006, 1'b0, "idle_status");
      add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, "empty_read");
      add_vec(1'b1, 1'b1, 16'h0018, 16'h0006, 1'b0, "clear_noop");
      add_vec(1'b0, 1'b1, 16'h0000, 16'h0006, 1'b0, "status_after_clear");
      run_tbl();

      // Single byte: exact line waveform, one check per cycle
      tx_got.delete(); tx_t.delete();
      wr(1'b0, 16'h00A5);
      chk("tx_pre_start", {15'b0, txd}, 16'h0001);
      bb = 8'hA5;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (k < 8) e = 16'h0000;
         else if (k < 72) e = {15'b0, bb[(k - 8) / 8]};
         else e = 16'h0001;
         chk($sformatf("tx_a5_cyc%0d", k), {15'b0, txd}, e);
         if (k % 8 == 0) begin
            peek(1'b1, v);
            chk($sformatf("tx_busy_cyc%0d", k), {15'b0, v[2]}, 16'h0000);
         end
      end
      tick();
      peek(1'b1, v); chk("tx_after_status", v, 16'h0006);
      chk("tx_a5_count", 16'(tx_got.size()), 16'd1);
      if (tx_got.size() > 0) chk("tx_a5_byte", {8'h0, tx_got[0]}, 16'h00A5);

      // Six back-to-back writes: one popped at once, four queued, one dropped
      tx_got.delete(); tx_t.delete();
      cs = 1'b1; we = 1'b1; addr = 1'b0;
      for (int i = 0; i < 6; i++) begin
         din = 16'h0031 + 16'(i);
         tick();
      end
      cs = 1'b0; we = 1'b0;
      peek(1'b1, v); chk("tx_full_status", v, 16'h0000);
      wait_tx_idle(1000);
      chk("tx_full_count", 16'(tx_got.size()), 16'd5);
      for (int i = 0; i < tx_got.size() && i < 5; i++)
         chk($sformatf("tx_full_byte%0d", i), {8'h0, tx_got[i]}, 16'h0031 + 16'(i));
      for (int i = 1; i < tx_t.size(); i++)
         chk($sformatf("tx_gap%0d", i), 16'(tx_t[i] - tx_t[i-1]), 16'(10 * CLKDIV));

      // RX good frame
      send_frame(8'h3C, 1'b1);
      idle(2);
      add_vec(1'b0, 1'b1, 16'h0000, 16'h0007, 1'b1, "rx_status");
      add_vec(1'b0, 1'b0, 16'h0000, 16'h003C, 1'b1, "rx_read");
      add_vec(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, "rx_reread");
      add_vec(1'b0, 1'b1, 16'h0000, 16'h0006, 1'b0, "rx_drained");
      run_tbl();

      // Framing error, then clear it
      send_frame(8'h55, 1'b0);
      idle(2);
      peek(1'b1, v); chk("frame_err_status", v, 16'h0016);
      chk("frame_err_irq", {15'b0, rx_irq}, 16'h0000);
      wr(1'b1, 16'h0010);
      peek(1'b1, v); chk("frame_err_cleared", v, 16'h0006);

      // Five frames into a four-deep FIFO
      for (int i = 0; i < 5; i++) send_frame(8'h11 + 8'(i), 1'b1);
      idle(2);
      peek(1'b1, v); chk("overrun_status", v, 16'h000F);
      for (int i = 0; i < 4; i++) begin
         rd(1'b0, v);
         chk($sformatf("overrun_drain%0d", i), v, 16'h0011 + 16'(i));
      end
      rd(1'b0, v); chk("overrun_drain_empty", v, 16'h0000);
      wr(1'b1, 16'h0008);
      peek(1'b1, v); chk("overrun_cleared", v, 16'h0006);

      // Short low glitch is rejected
      rxd = 1'b0;
      idle(2);
      rxd = 1'b1;
      idle(3 * CLKDIV);
      chk("glitch_irq", {15'b0, rx_irq}, 16'h0000);
      peek(1'b1, v); chk("glitch_status", v, 16'h0006);

      // Randomized RX traffic against a queue model
      m_over = 1'b0; m_frame = 1'b0;
      for (int it = 0; it < 24; it++) begin
         bb = 8'($urandom);
         st = ($urandom_range(0, 7) != 0);
         send_frame(bb, st);
         idle(2);
         if (!st) m_frame = 1'b1;
         else if (rxq.size() < 4) rxq.push_back(bb);
         else m_over = 1'b1;
         case ($urandom_range(0, 3))
            0, 1: begin
               rd(1'b0, v);
               if (rxq.size() > 0) e = {8'h0, rxq.pop_front()};
               else e = 16'h0000;
               chk($sformatf("rnd_rx_data%0d", it), v, e);
            end
            2: begin
               e = 16'($urandom_range(0, 3)) << 3;
               wr(1'b1, e);
               if (e[3]) m_over = 1'b0;
               if (e[4]) m_frame = 1'b0;
            end
            default: ;
         endcase
         idle(2);
         chk($sformatf("rnd_rx_irq%0d", it), {15'b0, rx_irq}, {15'b0, rxq.size() != 0});
         peek(1'b1, v);
         chk($sformatf("rnd_rx_status%0d", it), v,
             {11'b0, m_frame, m_over, 1'b1, 1'b1, rxq.size() != 0});
      end

      // Randomized TX bursts from idle: capacity is FIFO depth plus the shift register
      for (int it = 0; it < 4; it++) begin
         n = $urandom_range(1, 6);
         tx_got.delete(); tx_t.delete(); exq.delete();
         cs = 1'b1; we = 1'b1; addr = 1'b0;
         for (int k = 0; k < n; k++) begin
            bb = 8'($urandom);
            din = {8'($urandom), bb};
            if (k < 5) exq.push_back(bb);
            tick();
         end
         cs = 1'b0; we = 1'b0;
         wait_tx_idle(1000);
         chk($sformatf("rnd_tx_count%0d", it), 16'(tx_got.size()), 16'(exq.size()));
         for (int k = 0; k < exq.size() && k < tx_got.size(); k++)
            chk($sformatf("rnd_tx%0d_byte%0d", it, k), {8'h0, tx_got[k]}, {8'h0, exq[k]});
      end

      // Reset in the middle of the data bits with a second byte queued
      wr(1'b0, 16'h00C3);
      wr(1'b0, 16'h005A);
      idle(40);
      res = 1'b0;
      tick();
      chk("midrst_txd", {15'b0, txd}, 16'h0001);
      peek(1'b1, v); chk("midrst_status", v, 16'h0002);
      res = 1'b1;
      saw_low = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (txd !== 1'b1) saw_low = 1'b1;
      end
      chk("midrst_no_resume", {15'b0, saw_low}, 16'h0000);
      peek(1'b1, v); chk("midrst_after_status", v, 16'h0006);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
